// File: rtl/uart_tx_pkg.sv
// Shared UART constants, state encoding and bus types for the transmit path.
// The PARITY state is only present when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int   UART_DIV_RATE  = 868;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic ENABLE         = 1'b1;
  localparam logic DISABLE        = 1'b0;

  typedef logic [7:0] byte_data_t;
  typedef logic [2:0] uart_bit_cnt_t;

  localparam uart_bit_cnt_t UART_LAST_DATA_BIT = 3'd7;

  typedef enum logic [2:0] {
    UART_STATE_IDLE   = 3'd0,
    UART_STATE_START  = 3'd1,
    UART_STATE_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    UART_STATE_PARITY = 3'd3,
`endif
    UART_STATE_STOP   = 3'd4
  } uart_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input byte_data_t data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side handshake of the UART transmitter: write strobe, data, status and line.
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic       tx_start;
  byte_data_t tx_data;
  logic       tx_full;
  logic       tx_busy;
  logic       tx_end;
  logic       tx;

  modport master (
    output tx_start, tx_data,
    input  tx_full, tx_busy, tx_end, tx
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_full, tx_busy, tx_end, tx
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO queueing bytes ahead of the serialiser; full is registered
// from the next occupancy, so a push is judged against last cycle's level.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  // Storage needs no reset; pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed 8N1 serialiser, LSB first, idle-high line.
// Defining UART_TX_PARITY_EN adds an even parity bit (8E1); must match uart_rx.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DIV_RATE   = UART_DIV_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam int             DIV_W      = $clog2(DIV_RATE);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_RATE - 1);

  uart_state_t      state, state_next;
  logic [DIV_W-1:0] div_cnt, div_cnt_next;
  uart_bit_cnt_t    bit_cnt, bit_cnt_next;
  byte_data_t       shift, shift_next;
  logic             tx_reg, tx_next;
  logic             tx_end_reg, tx_end_next;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  byte_data_t       fifo_data;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity, parity_next;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.tx_start),
    .push_data (bus.tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bit_done    = (div_cnt == '0);
  assign bus.tx      = tx_reg;
  assign bus.tx_end  = tx_end_reg;
  assign bus.tx_full = fifo_full;
  assign bus.tx_busy = (state != UART_STATE_IDLE) || !fifo_empty;

  // Next-state logic. Popping a new byte always drives the start bit on the same
  // edge, both from IDLE and at the end of a stop bit, so frames run back-to-back.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    tx_next      = tx_reg;
    tx_end_next  = DISABLE;
    fifo_pop     = DISABLE;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif

    unique case (state)
      UART_STATE_IDLE: begin
        tx_next = UART_STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop     = ENABLE;
          shift_next   = fifo_data;
          tx_next      = UART_START_BIT;
          div_cnt_next = DIV_RELOAD;
          bit_cnt_next = '0;
          state_next   = UART_STATE_START;
`ifdef UART_TX_PARITY_EN
          parity_next  = even_parity(fifo_data);
`endif
        end
      end

      UART_STATE_START: begin
        if (bit_done) begin
          tx_next      = shift[0];
          shift_next   = shift >> 1;
          div_cnt_next = DIV_RELOAD;
          bit_cnt_next = '0;
          state_next   = UART_STATE_DATA;
        end else begin
          div_cnt_next = div_cnt - 1'b1;
        end
      end

      UART_STATE_DATA: begin
        if (bit_done) begin
          div_cnt_next = DIV_RELOAD;
          if (bit_cnt == UART_LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity;
            state_next = UART_STATE_PARITY;
`else
            tx_next    = UART_STOP_BIT;
            state_next = UART_STATE_STOP;
`endif
          end else begin
            tx_next      = shift[0];
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt - 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      UART_STATE_PARITY: begin
        if (bit_done) begin
          tx_next      = UART_STOP_BIT;
          div_cnt_next = DIV_RELOAD;
          state_next   = UART_STATE_STOP;
        end else begin
          div_cnt_next = div_cnt - 1'b1;
        end
      end
`endif

      UART_STATE_STOP: begin
        if (bit_done) begin
          tx_end_next = ENABLE;
          if (!fifo_empty) begin
            fifo_pop     = ENABLE;
            shift_next   = fifo_data;
            tx_next      = UART_START_BIT;
            div_cnt_next = DIV_RELOAD;
            bit_cnt_next = '0;
            state_next   = UART_STATE_START;
`ifdef UART_TX_PARITY_EN
            parity_next  = even_parity(fifo_data);
`endif
          end else begin
            tx_next    = UART_STOP_BIT;
            state_next = UART_STATE_IDLE;
          end
        end else begin
          div_cnt_next = div_cnt - 1'b1;
        end
      end

      default: begin
        tx_next    = UART_STOP_BIT;
        state_next = UART_STATE_IDLE;
      end
    endcase
  end

  // Reset forces the line high immediately, mid-frame included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UART_STATE_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_reg     <= UART_STOP_BIT;
      tx_end_reg <= DISABLE;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      div_cnt    <= div_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      tx_reg     <= tx_next;
      tx_end_reg <= tx_end_next;
`ifdef UART_TX_PARITY_EN
      parity     <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model, serial receiver,
// vector table and hand-written corner sequences; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_if bus_if ();

  uart_tx #(
    .DIV_RATE   (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: a byte queue plus the remaining length of the frame on the wire.
  byte_data_t mq[$];
  byte_data_t exp_q[$];
  logic       m_full = 1'b0;
  logic       m_end  = 1'b0;
  int         m_rem  = 0;
  int         m_pos  = 0;
  byte_data_t m_cur  = '0;

  // Independent serial receiver on the DUT line.
  byte_data_t rx_q[$];
  int         end_q[$];
  logic       rx_active = 1'b0;
  logic       rx_prev   = 1'b1;
  int         rx_start  = 0;
  logic [10:0] rx_bits  = '0;

  typedef struct {
    byte_data_t data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic frameBit(input byte_data_t b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic modelStep();
    m_end = 1'b0;
    if (rst) begin
      mq.delete();
      m_full = 1'b0;
      m_rem  = 0;
      m_pos  = 0;
      return;
    end
    if (m_rem > 0) begin
      m_rem--;
      m_pos++;
      if (m_rem == 0) begin
        m_end = 1'b1;
        exp_q.push_back(m_cur);
      end
    end
    if (m_rem == 0 && mq.size() > 0) begin
      m_cur = mq.pop_front();
      m_rem = FRAME_CYC;
      m_pos = 0;
    end
    if (bus_if.tx_start && !m_full) mq.push_back(bus_if.tx_data);
    m_full = (mq.size() == DEPTH);
  endtask

  task automatic rxStep();
    int off;
    if (rst) begin
      rx_active = 1'b0;
      rx_prev   = 1'b1;
      return;
    end
    if (!rx_active && rx_prev && !bus_if.tx) begin
      rx_active = 1'b1;
      rx_start  = cyc;
    end
    if (rx_active) begin
      off = cyc - rx_start;
      if (off % DIV == DIV / 2) begin
        rx_bits[off / DIV] = bus_if.tx;
        if (off / DIV == FRAME_BITS - 1) begin
          rx_active = 1'b0;
          checkOutput("rx_start_bit", rx_bits[0], 0);
          checkOutput("rx_stop_bit", rx_bits[FRAME_BITS-1], 1);
`ifdef UART_TX_PARITY_EN
          checkOutput("rx_parity", rx_bits[9], ^rx_bits[8:1]);
`endif
          rx_q.push_back(rx_bits[8:1]);
        end
      end
    end
    rx_prev = bus_if.tx;
  endtask

  // One clock: advance the model on the edge, compare all outputs 1ns later.
  task automatic tick();
    logic m_tx;
    logic m_busy;
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    m_tx   = (m_rem == 0) ? 1'b1 : frameBit(m_cur, m_pos / DIV);
    m_busy = (m_rem != 0) || (mq.size() != 0);
    checkOutput("model_tx", bus_if.tx, m_tx);
    checkOutput("model_tx_end", bus_if.tx_end, m_end);
    checkOutput("model_tx_busy", bus_if.tx_busy, m_busy);
    checkOutput("model_tx_full", bus_if.tx_full, m_full);
    if (bus_if.tx_end) end_q.push_back(cyc);
    rxStep();
  endtask

  task automatic applyStimulus(input byte_data_t data);
    bus_if.tx_start = 1'b1;
    bus_if.tx_data  = data;
    tick();
    bus_if.tx_start = 1'b0;
    bus_if.tx_data  = 8'h00;
  endtask

  task automatic waitIdle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!bus_if.tx_busy) break;
      tick();
    end
    checkOutput("idle_reached", bus_if.tx_busy, 0);
  endtask

  initial begin
    int rx_base;
    int end_base;
    logic exp_bit;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1};

    bus_if.tx_start = 1'b0;
    bus_if.tx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: quiet line, nothing pending.
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput("idle_tx", bus_if.tx, 1);
      checkOutput("idle_busy", bus_if.tx_busy, 0);
      checkOutput("idle_end", bus_if.tx_end, 0);
      checkOutput("idle_full", bus_if.tx_full, 0);
    end

    // Single frames against the vector table, sampled at bit centres.
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].data);
      checkOutput("pre_start_tx", bus_if.tx, 1);
      checkOutput("busy_rise", bus_if.tx_busy, 1);
      tick();
      checkOutput("start_edge_tx", bus_if.tx, 0);
      repeat (DIV / 2) tick();
      for (int k = 0; k < FRAME_BITS; k++) begin
        if (k > 0) repeat (DIV) tick();
        if (k < 9) exp_bit = vecs[v].frame[k];
        else if (FRAME_BITS == 11 && k == 9) exp_bit = vecs[v].par;
        else exp_bit = 1'b1;
        checkOutput($sformatf("vec%0d_bit%0d", v, k), bus_if.tx, exp_bit);
      end
      for (int i = 0; i < FRAME_CYC; i++) begin
        if (bus_if.tx_end) break;
        tick();
      end
      checkOutput("tx_end_seen", bus_if.tx_end, 1);
      tick();
      checkOutput("end_one_cycle", bus_if.tx_end, 0);
      checkOutput("busy_after_end", bus_if.tx_busy, 0);
    end

    // Two bytes back-to-back: pulses one frame apart.
    rx_base  = rx_q.size();
    end_base = end_q.size();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    waitIdle(4 * FRAME_CYC);
    checkOutput("b2b_end_count", end_q.size() - end_base, 2);
    if (end_q.size() - end_base == 2)
      checkOutput("b2b_end_spacing", end_q[end_base+1] - end_q[end_base], FRAME_CYC);
    checkOutput("b2b_rx_count", rx_q.size() - rx_base, 2);
    if (rx_q.size() - rx_base == 2) begin
      checkOutput("b2b_rx0", rx_q[rx_base], 8'hA5);
      checkOutput("b2b_rx1", rx_q[rx_base+1], 8'h01);
    end

    // Six pushes in a row: the sixth meets a full FIFO and is dropped.
    rx_base  = rx_q.size();
    end_base = end_q.size();
    for (int i = 0; i < 6; i++) begin
      bus_if.tx_start = 1'b1;
      bus_if.tx_data  = 8'h11 + 8'(i);
      tick();
      if (i == 3) checkOutput("full_after_push4", bus_if.tx_full, 0);
      if (i == 4) checkOutput("full_after_push5", bus_if.tx_full, 1);
    end
    bus_if.tx_start = 1'b0;
    waitIdle(7 * FRAME_CYC);
    checkOutput("burst_end_count", end_q.size() - end_base, 5);
    checkOutput("burst_rx_count", rx_q.size() - rx_base, 5);
    for (int i = 0; i < 5; i++)
      if (rx_base + i < rx_q.size())
        checkOutput($sformatf("burst_rx%0d", i), rx_q[rx_base+i], 8'h11 + 8'(i));

    // Reset in the middle of a data bit with two bytes still queued.
    applyStimulus(8'h3C);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    repeat (DIV) tick();
    checkOutput("mid_data_tx", bus_if.tx, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_tx", bus_if.tx, 1);
    checkOutput("async_rst_busy", bus_if.tx_busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    rx_base  = rx_q.size();
    end_base = end_q.size();
    repeat (100) tick();
    checkOutput("post_rst_end_count", end_q.size() - end_base, 0);
    checkOutput("post_rst_rx_count", rx_q.size() - rx_base, 0);
    checkOutput("post_rst_busy", bus_if.tx_busy, 0);

    // Push on the very edge that pops from a full FIFO: still refused.
    rx_base = rx_q.size();
    for (int i = 0; i < 5; i++) applyStimulus(8'h21 + 8'(i));
    repeat (FRAME_CYC - 4) tick();
    checkOutput("full_before_pop", bus_if.tx_full, 1);
    bus_if.tx_start = 1'b1;
    bus_if.tx_data  = 8'hEE;
    tick();
    bus_if.tx_start = 1'b0;
    checkOutput("pop_edge_end", bus_if.tx_end, 1);
    checkOutput("full_after_pop", bus_if.tx_full, 0);
    waitIdle(6 * FRAME_CYC);
    checkOutput("race_rx_count", rx_q.size() - rx_base, 5);
    for (int i = 0; i < 5; i++)
      if (rx_base + i < rx_q.size())
        checkOutput($sformatf("race_rx%0d", i), rx_q[rx_base+i], 8'h21 + 8'(i));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus_if.tx_start = ($urandom_range(0, 5) == 0);
      bus_if.tx_data  = 8'($urandom);
      tick();
    end
    bus_if.tx_start = 1'b0;
    waitIdle((DEPTH + 2) * FRAME_CYC);

    checkOutput("total_rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("total_rx%0d", i), rx_q[i], exp_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter with a small transmit FIFO. Accepts bytes from the CPU-side bus/peripheral logic via a one-cycle write strobe, queues them, and serialises each as 8N1 (optionally 8E1) frames, LSB first, on the `tx` line. It is the transmit half of the UART peripheral, paired with `uart_rx` on the same `UART_DIV_RATE` bit timing.

## Interface
- `DIV_RATE`, default `UART_DIV_RATE`: clocks per bit period (≥2).
- `FIFO_DEPTH`, default 4: transmit FIFO entries (power of two, ≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `tx_start`  in  1  write strobe; pushes `tx_data` when `tx_full` is low.
- `tx_data`  in  8  byte to transmit, sampled with `tx_start`.
- `tx_full`  out  1  FIFO full; writes this cycle are dropped.
- `tx_busy`  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- `tx_end`  out  1  one-cycle pulse at the end of each stop bit.
- `tx`  out  1  serial output; idle level 1.

## Operation
- States: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register, drive `tx`=0, load `div_cnt`=DIV_RATE-1, go to START.
- Each bit state holds `tx` while `div_cnt` counts down. At `div_cnt`=0, advance and reload DIV_RATE-1. Every bit lasts exactly DIV_RATE clocks.
- START → DATA: drive shift[0] and shift right. `bit_cnt` runs 0..7; after bit 7 go to PARITY/STOP.
- PARITY: drive XOR of the 8 data bits (even parity).
- STOP: `tx`=1. At `div_cnt`=0, pulse `tx_end`.
  - If the FIFO is non-empty, pop on the same edge, drive `tx`=0 and enter START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- FIFO:
  - Push when `tx_start && !tx_full`.
  - Push and pop in the same cycle leave occupancy unchanged.
  - `tx_full` is registered from occupancy, so a push in the same cycle as a pop while full is still refused.
  - `tx_start` while full is silently dropped; no error flag.
- Width rules: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is one bit wider. `div_cnt` is wide enough for DIV_RATE-1.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_end`=0, `tx_full`=0, FIFO empty, state IDLE, counters 0.
- Latency: byte accepted at edge E0 while IDLE and FIFO empty → pop and `tx` falls at edge E1. The start bit spans E1..E1+DIV_RATE.
- Frame length: 10×DIV_RATE clocks, or 11×DIV_RATE with parity.
- `tx_end` is high for the single cycle after the final stop-bit edge.
- `tx_busy` rises the cycle after an accepted push into an idle block. It falls the cycle after the last `tx_end` when the FIFO is empty.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously). Queued bytes are discarded and no `tx_end` is generated.
- `tx_data` is don't-care when `tx_start` is low.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state exists; frames are 8E1 (11 bits).
- Not defined: no PARITY state or logic; frames are 8N1 (10 bits).
- The macro must match the `uart_rx` build.

## Structure
- Shared `defines.v` holds the following; this block adds no local literals for them:
  - `UART_DIV_RATE`, `UART_START_BIT` (0), `UART_STOP_BIT` (1)
  - state encodings: `UART_STATE_IDLE` plus new `UART_STATE_START/DATA/PARITY/STOP`
  - `UartStateBus`, `UartDivCntBus`, `UartBitCntBus`, `ByteDataBus`
  - `ENABLE`/`DISABLE`
- One sub-module: `uart_tx_fifo` (synchronous FIFO).
  - Ports: push/data in, pop/data out, `empty`, `full`.
  - Same `clk`/`rst`, async active-high reset.
- FSM, shifter and counters live in `uart_tx`.

## Test plan
All with DIV_RATE=4.
- Reset, then idle 50 cycles → `tx`=1, `tx_busy`=0, `tx_end`=0, `tx_full`=0 throughout.
- Push 0xA5 once → `tx` falls one edge after the push. Then 4-cycle bits 0,1,0,1,0,0,1,0,1,1 (40 cycles), one `tx_end` pulse, `tx_busy` drops after it.
- With `UART_TX_PARITY_EN`, push 0xA5 then 0x01 → 0xA5 has parity bit 0 (44 cycles). 0x01 follows back-to-back with no gap and parity bit 1. Two `tx_end` pulses 44 cycles apart.
- Push 0x11..0x16 on 6 consecutive cycles into an idle block:
  - `tx_full` asserts after the 5th push; 0x16 is dropped.
  - Exactly frames 0x11..0x15 appear, back-to-back.
  - 5 `tx_end` pulses.
- Assert `rst` mid-DATA of 0x3C with 2 bytes queued → `tx`=1 in the same cycle. No further frames or `tx_end` after release; `tx_busy`=0.
- Push while full and a pop occurs on the same edge → the push is refused and the FIFO contents are unchanged (checked by the serialised byte order).
